// File: rtl/truth_table_sweeper_if.sv
// Host/function-block side bundle for truth_table_sweeper: sweep control,
// expected/captured tables, and the function block's input vector and output.
interface truth_table_sweeper_if #(
  parameter int N_INPUTS = 4
);
  localparam int TBL_W = 1 << N_INPUTS;

  logic                start;
  logic [TBL_W-1:0]    expected;
  logic                fn_out;
  logic [N_INPUTS-1:0] fn_in;
  logic                busy;
  logic                done;
  logic [TBL_W-1:0]    table_out;
  logic                match;
  logic [N_INPUTS:0]   mismatch_cnt;

  modport master (
    output start, expected, fn_out,
    input  fn_in, busy, done, table_out, match, mismatch_cnt
  );

  modport slave (
    input  start, expected, fn_out,
    output fn_in, busy, done, table_out, match, mismatch_cnt
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_INPUTS vectors into a combinational function block, captures its truth
// table and counts mismatches against a latched expected table. TT_STOP_ON_MISMATCH_EN ends early.
module truth_table_sweeper #(
  parameter int N_INPUTS = 4,
  parameter int SETTLE   = 2
) (
  input logic              clk,
  input logic              rst,
  truth_table_sweeper_if.slave bus
);
  localparam int TBL_W = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_VEC = '1;
  localparam logic [7:0] SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

`ifdef TT_STOP_ON_MISMATCH_EN
  localparam bit STOP_ON_MISS = 1'b1;
`else
  localparam bit STOP_ON_MISS = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  state_t              state, state_nxt;
  logic [N_INPUTS-1:0] fn_in_q, fn_in_nxt;
  logic [7:0]          settle_q, settle_nxt;
  logic [TBL_W-1:0]    exp_q, exp_nxt;
  logic [TBL_W-1:0]    table_q, table_nxt;
  logic [N_INPUTS:0]   cnt_q, cnt_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;
  logic                match_q, match_nxt;
  logic                miss;
  logic                last_sample;

  // Never wraps: the count tops out at 2^N, below the all-ones code.
  function automatic logic [N_INPUTS:0] cnt_inc(input logic [N_INPUTS:0] c);
    cnt_inc = (c == '1) ? c : c + 1'b1;
  endfunction

  assign miss        = bus.fn_out ^ exp_q[fn_in_q];
  assign last_sample = (fn_in_q == LAST_VEC) || (STOP_ON_MISS && miss);

  always_comb begin
    state_nxt  = state;
    fn_in_nxt  = fn_in_q;
    settle_nxt = settle_q;
    exp_nxt    = exp_q;
    table_nxt  = table_q;
    cnt_nxt    = cnt_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    match_nxt  = match_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          exp_nxt    = bus.expected;
          table_nxt  = '0;
          cnt_nxt    = '0;
          match_nxt  = 1'b0;
          fn_in_nxt  = '0;
          settle_nxt = '0;
          busy_nxt   = 1'b1;
          state_nxt  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_nxt = settle_q + 8'd1;
        if (settle_q == SETTLE_LAST) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        table_nxt[fn_in_q] = bus.fn_out;
        if (miss) cnt_nxt = cnt_inc(cnt_q);
        if (last_sample) begin
          state_nxt = ST_FINISH;
        end else begin
          fn_in_nxt  = fn_in_q + 1'b1;
          settle_nxt = '0;
          state_nxt  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        match_nxt = (cnt_q == '0);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset clears the captured results as well as control, so a mid-sweep abort leaves no stale table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fn_in_q  <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fn_in_q  <= fn_in_nxt;
      settle_q <= settle_nxt;
      exp_q    <= exp_nxt;
      table_q  <= table_nxt;
      cnt_q    <= cnt_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      match_q  <= match_nxt;
    end
  end

  assign bus.fn_in        = fn_in_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_out    = table_q;
  assign bus.match        = match_q;
  assign bus.mismatch_cnt = cnt_q;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer for an N-input, 1-output combinational logic function block of the case-statement truth-table type.
- Walks the input vector through all 2^N combinations, waits a settle interval on each, and samples the function output into a captured truth-table register.
- Compares the captured table against an expected table and reports the mismatch count.
- Sits between a test/configuration host and the function block; it is the only driver of that block's inputs.

Parameters:
- N_INPUTS, 4, number of function inputs (1..8); table width is 2^N_INPUTS.
- SETTLE, 2, cycles each vector is held before sampling (0..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- expected  input  2^N_INPUTS  expected table; bit i = required output for vector i.
- fn_out  input  1  output of the function block under control.
- fn_in  output  N_INPUTS  vector driven to the function block; MSB = inp1, LSB = inpN.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  2^N_INPUTS  captured table; bit i = fn_out sampled for vector i.
- match  output  1  high when table_out == latched expected; valid from done until the next start.
- mismatch_cnt  output  N_INPUTS+1  number of differing table bits.

Behaviour:
- Reset (synchronous, active-high, any state including mid-sweep): state IDLE; fn_in=0, busy=0, done=0, table_out=0, match=0, mismatch_cnt=0, internal vector/settle counters=0, latched expected=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: start=1 latches expected, clears table_out and mismatch_cnt, sets match=0, fn_in=0, settle count=0, busy=1. Next state is SETTLE, or SAMPLE if SETTLE==0.
- SETTLE: increment settle count; after SETTLE cycles in this state go to SAMPLE. fn_in stays stable.
- SAMPLE (one cycle): table_out[fn_in] <= fn_out. If fn_out != latched expected[fn_in], mismatch_cnt <= mismatch_cnt+1.
  - If fn_in == 2^N-1, go to FINISH.
  - Otherwise fn_in <= fn_in+1, clear settle count, and go to SETTLE (or SAMPLE if SETTLE==0).
- FINISH (one cycle): done=1, busy=0, match = (mismatch_cnt==0), return to IDLE.
- Timing: each vector occupies SETTLE+1 cycles. If start is sampled at cycle 0, done is high at cycle 2^N*(SETTLE+1)+1. Default parameters give cycle 49.
- fn_in never wraps. The vector counter stops at 2^N-1, and fn_in holds the last vector after the sweep until the next start or reset.
- start while busy, or in the FINISH cycle: ignored, no restart, no effect on counters.
- Changes on expected during a sweep: ignored; only the value latched at start is used.
- table_out, match and mismatch_cnt hold their values in IDLE until the next accepted start.
- mismatch_cnt saturates naturally: the maximum is 2^N, which fits in N+1 bits.

Optional Feature:
- Macro: TT_STOP_ON_MISMATCH_EN.
- Defined: at the first SAMPLE where a mismatch is counted, go directly to FINISH. mismatch_cnt=1, match=0, fn_in holds the failing vector, and table_out bits above that vector remain 0. Done arrives early: (k+1)*(SETTLE+1)+1 cycles after start for failing vector k.
- Undefined: a full sweep always runs; the behaviour above applies unchanged.

Test Plan:
- Defaults, fn_out modelled as function with ones at vectors 1010,1011,1100, expected=16'h1C00 -> fn_in steps 0..15, done at cycle 49, table_out=16'h1C00, match=1, mismatch_cnt=0.
- Same model, expected=16'h1C01 -> table_out=16'h1C00, match=0, mismatch_cnt=1; with TT_STOP_ON_MISMATCH_EN: done at cycle 4, fn_in=0, table_out=0.
- Constant fn_out=1, expected=16'h0000 -> table_out=16'hFFFF, mismatch_cnt=16, match=0.
- SETTLE=0, N_INPUTS=2, fn_out=fn_in[1]&fn_in[0], expected=4'h8 -> done at cycle 5, table_out=4'h8, match=1.
- start re-pulsed at cycle 10 of a default sweep, and expected changed to 16'hFFFF at cycle 20 -> no restart, done still at cycle 49, result based on the original expected.
- rst=1 at cycle 20 of a sweep -> next cycle busy=0, fn_in=0, table_out=0, mismatch_cnt=0, no done pulse; a fresh start then completes normally at +49.
